// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron datapath blocks.
//   NEURON_W     default operand width of the membrane-potential datapath
//   bss_state_t  control states of the bit-serial subtractor
package neuron_pkg;

  localparam int NEURON_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bss_state_t;

endpackage

// File: rtl/half_sub_cell.sv
// Half-subtractor cell, the subtract counterpart of the half-adder cell.
// Two of these plus an OR gate form one full-subtractor bit.
// Ports:
//   x   minuend bit
//   y   subtrahend bit
//   d   difference bit (x ^ y)
//   bo  borrow out     (~x & y)
module half_sub_cell
  import neuron_pkg::*;
(
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/bit_serial_sub.sv
// Bit-serial subtractor: computes a - b LSB first, one bit per clock, with
// optional clamp-to-zero on underflow. Used for leak/inhibition decrement of
// the membrane potential.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    operand handshake; a, b sampled on the accept edge
//   a, b                 unsigned minuend / subtrahend
//   bit_out, bit_valid   raw (wrapped) difference bits while shifting
//   out_valid/out_ready  result handshake
//   diff                 result, zero on underflow when SATURATE=1
//   borrow_out           1 when a < b
module bit_serial_sub
  import neuron_pkg::*;
#(
  parameter int WIDTH    = NEURON_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  bss_state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_shift;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             d1, bo1, d, bo2, bnext;
  logic             last_bit;

  // Full-subtractor bit: first cell subtracts the operand bits, second cell
  // subtracts the stored borrow from that partial difference.
  half_sub_cell u_hs_ab (.x(a_sr[0]), .y(b_sr[0]), .d(d1), .bo(bo1));
  half_sub_cell u_hs_br (.x(d1),      .y(borrow),  .d(d),  .bo(bo2));

  assign bnext     = bo1 | bo2;
  assign last_bit  = (cnt == LAST);
  // Result register after this cycle's bit enters at the MSB.
  assign res_shift = {d, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    bit_valid  = 1'b0;
    bit_out    = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        bit_valid = 1'b1;
        bit_out   = d;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_shift;
      borrow <= bnext;
      if (last_bit) begin
        // The final borrow is the underflow flag; hold the counter at its
        // terminal value rather than letting it wrap.
        borrow_out <= bnext;
        diff       <= (SATURATE && bnext) ? '0 : res_shift;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_sub.sv
module tb_bit_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a, b;
  logic       out_ready;

  logic       in_ready_s, bit_out_s, bit_valid_s, out_valid_s, borrow_s;
  logic [7:0] diff_s;
  logic       in_ready_w, bit_out_w, bit_valid_w, out_valid_w, borrow_w;
  logic [7:0] diff_w;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_serial_sub #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .bit_out(bit_out_s), .bit_valid(bit_valid_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .diff(diff_s),
    .borrow_out(borrow_s)
  );

  bit_serial_sub #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .bit_out(bit_out_w), .bit_valid(bit_valid_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .diff(diff_w),
    .borrow_out(borrow_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  {in_ready_s, in_ready_w},   2'b11);
    chk({tag, "_out_valid"}, {out_valid_s, out_valid_w}, 2'b00);
    chk({tag, "_bit_valid"}, {bit_valid_s, bit_valid_w}, 2'b00);
    chk({tag, "_bit_out"},   {bit_out_s, bit_out_w},     2'b00);
    chk({tag, "_diff"},      {diff_s, diff_w},           16'h0000);
    chk({tag, "_borrow"},    {borrow_s, borrow_w},       2'b00);
  endtask

  // One full operation on both instances, called at a negedge.
  // hold = number of DONE cycles with out_ready low and junk operands offered.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int hold);
    logic [7:0] raw, sat;
    logic       bor;
    int         w;
    raw = av - bv;
    bor = (av < bv);
    sat = bor ? 8'd0 : raw;
    w = 0;
    while (in_ready_s !== 1'b1 && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("wait_in_ready", in_ready_s, 1'b1);
    a = av; b = bv; in_valid = 1'b1; out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("bit_valid", {bit_valid_s, bit_valid_w}, 2'b11);
      chk("bit_out", {bit_out_s, bit_out_w}, {raw[k], raw[k]});
      chk("shift_busy", {in_ready_s, out_valid_s, out_valid_w}, 3'b000);
      a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
    end
    chk("out_valid", {out_valid_s, out_valid_w}, 2'b11);
    chk("diff_sat", diff_s, sat);
    chk("diff_wrap", diff_w, raw);
    chk("borrow_out", {borrow_s, borrow_w}, {bor, bor});
    chk("done_idle", {in_ready_s, in_ready_w, bit_valid_s}, 3'b000);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", {out_valid_s, out_valid_w, in_ready_s, in_ready_w}, 4'b1100);
      chk("hold_diff", {diff_s, diff_w}, {sat, raw});
      chk("hold_borrow", {borrow_s, borrow_w}, {bor, bor});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("back_idle", {out_valid_s, in_ready_s, in_ready_w}, 3'b011);
    $display("op a=%0d b=%0d hold=%0d -> sat=%0d wrap=%0d borrow=%0b", av, bv, hold, sat, raw, bor);
  endtask

  initial begin
    int         acc_cyc[2];
    int         n_acc;
    logic [7:0] got_q[$];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd200, 8'd55, 0);
    run_op(8'd55, 8'd200, 0);
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'd0, 8'd1, 0);
    run_op(8'd9, 8'd3, 5);
    run_op(8'd9, 8'd3, 0);

    // Abort mid-shift with an asynchronous reset.
    a = 8'd100; b = 8'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", {in_ready_s, in_ready_w}, 2'b11);
    run_op(8'd10, 8'd4, 0);

    // Back-to-back with in_valid held high.
    in_valid = 1'b1; a = 8'd20; b = 8'd5; out_ready = 1'b1; n_acc = 0;
    for (int c = 0; c < 40 && got_q.size() < 2; c++) begin
      if (in_ready_s && in_valid && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (out_valid_s) got_q.push_back(diff_s);
      @(negedge clk);
      if (n_acc == 1) begin a = 8'd7; b = 8'd7; end
      if (n_acc == 2) in_valid = 1'b0;
    end
    chk("b2b_accepts", n_acc, 2);
    if (n_acc == 2) chk("b2b_interval", acc_cyc[1] - acc_cyc[0], 10);
    chk("b2b_results", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("b2b_first", got_q[0], 8'd15);
      chk("b2b_second", got_q[1], 8'd0);
    end
    $display("back-to-back: accepts=%0d results=%0d", n_acc, got_q.size());

    repeat (2) @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
